// File: rtl/step_move_scheduler.sv
// step_move_scheduler: two-requester round-robin arbiter, command FIFO and move sequencer for step_motor_drive; define STEP_SCHED_ABORT_EN to add the abort input
module step_move_scheduler #(
    parameter int          DEPTH         = 4,
    parameter logic [23:0] START_TIMEOUT = 24'd1048576,
    parameter logic [23:0] SETTLE        = 24'd524288
) (
    input  logic       clk,
    input  logic       reset,
`ifdef STEP_SCHED_ABORT_EN
    input  logic       abort,
`endif
    input  logic       req0_valid,
    input  logic [3:0] req0_digit,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_digit,
    output logic       req1_ready,
    input  logic [3:0] coils,
    output logic       drv_en,
    output logic       drv_load,
    output logic [3:0] drv_digit,
    output logic       busy,
    output logic [3:0] cur_digit,
    output logic       drop,
    output logic       done
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_MOVING, S_SETTLE, S_DONE} state_t;
    state_t        state, state_n;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic [3:0]    coils_m, coils_s;
    logic [23:0]   timer;
    logic          ptr, halt, full, both, acc0, acc1, acc, push, pop;
    logic [3:0]    acc_digit;
`ifdef STEP_SCHED_ABORT_EN
    assign halt = abort;
`else
    assign halt = 1'b0;
`endif
    assign drv_en     = ~reset & ~halt;
    assign full       = count == (AW+1)'(DEPTH);
    assign both       = req0_valid & req1_valid;
    assign req0_ready = ~reset & ~halt & ~full & ~(both & ptr);
    assign req1_ready = ~reset & ~halt & ~full & ~(both & ~ptr);
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;
    assign acc        = acc0 | acc1;
    assign acc_digit  = acc0 ? req0_digit : req1_digit;
    assign push       = acc & (acc_digit <= 4'd9);
    assign pop        = (state == S_IDLE) & (count != '0) & ~halt;
    assign drv_load   = state == S_LOAD;
    assign done       = (state == S_DONE) & ~halt;
    assign busy       = (state != S_IDLE) | (count != '0);

    // two-flop synchronizer on the coil feedback from the driver's clock domain
    always_ff @(posedge clk) begin
        if (reset) begin
            coils_m <= '0;
            coils_s <= '0;
        end else begin
            coils_m <= coils;
            coils_s <= coils_m;
        end
    end

    // round-robin pointer moves only on contested grants; invalid digits pulse drop
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr  <= 1'b0;
            drop <= 1'b0;
        end else begin
            drop <= acc & ~push;
            if (both & ~full & ~halt) ptr <= ~ptr;
        end
    end

    // command FIFO with wrapping pointers; abort flushes it
    always_ff @(posedge clk) begin
        if (reset | halt) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= acc_digit;
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // sequencer next state: load, wait for coil activity, follow the move, settle
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = (count != '0) ? S_LOAD : S_IDLE;
            S_LOAD:   state_n = S_WAIT;
            S_WAIT:   state_n = (coils_s != '0) ? S_MOVING : (timer >= START_TIMEOUT) ? S_DONE : S_WAIT;
            S_MOVING: state_n = (coils_s == '0) ? S_SETTLE : S_MOVING;
            S_SETTLE: state_n = (coils_s != '0) ? S_MOVING : (timer >= SETTLE - 24'd1) ? S_DONE : S_SETTLE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (halt) state_n = S_IDLE;
    end

    // state register, saturating timer, loaded and completed digits
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            drv_digit <= '0;
            cur_digit <= '0;
        end else begin
            state <= state_n;
            timer <= (state == S_LOAD || state == S_MOVING) ? '0 : (&timer) ? timer : timer + 24'd1;
            if (pop) drv_digit <= mem[rp];
            if (done) cur_digit <= drv_digit;
        end
    end
endmodule

// File: tb/tb_step_move_scheduler.sv
// tb_step_move_scheduler: table vectors, directed multi-cycle sequences and a randomized run against a queue model
module tb_step_move_scheduler;
    localparam int          DEPTH      = 4;
    localparam logic [23:0] ST         = 24'd8;
    localparam logic [23:0] SE         = 24'd4;
    localparam int          NOMOVE_LAT = 10;
    localparam int          SETTLE_LAT = 7;

    typedef struct {
        logic       v0;
        logic [3:0] d0;
        logic       v1;
        logic [3:0] d1;
        logic       r0;
        logic       r1;
        logic       dp;
        logic       ld;
        logic [3:0] lg;
    } vec_t;

    logic       clk = 1'b0, reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0] req0_digit = '0, req1_digit = '0, coils = '0;
    logic       req0_ready, req1_ready, drv_en, drv_load, busy, drop, done;
    logic [3:0] drv_digit, cur_digit;
`ifdef STEP_SCHED_ABORT_EN
    logic       abort = 1'b0;
`endif

    step_move_scheduler #(.DEPTH(DEPTH), .START_TIMEOUT(ST), .SETTLE(SE)) dut (
        .clk(clk),
        .reset(reset),
`ifdef STEP_SCHED_ABORT_EN
        .abort(abort),
`endif
        .req0_valid(req0_valid),
        .req0_digit(req0_digit),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_digit(req1_digit),
        .req1_ready(req1_ready),
        .coils(coils),
        .drv_en(drv_en),
        .drv_load(drv_load),
        .drv_digit(drv_digit),
        .busy(busy),
        .cur_digit(cur_digit),
        .drop(drop),
        .done(done)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0, cyc = 0, done_cnt = 0, drop_cnt = 0;
    int   load_q[$], load_cyc[$], done_cyc[$];
    int   mq[$];
    bit   mptr, cur_pend;
    int   outst, last_ld, coil_run;
    vec_t tv[9];
    int   fd[5];
    int   pe[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (drv_load) begin
            load_q.push_back(int'(drv_digit));
            load_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        if (drop) drop_cnt++;
    endtask

    task automatic idle_in();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle_in();
        coils = '0;
        repeat (n) tick();
        reset = 1'b0;
        load_q.delete();
        load_cyc.delete();
        done_cyc.delete();
        done_cnt = 0;
        drop_cnt = 0;
    endtask

    task automatic wait_load(input int n, input string name);
        int t = 0;
        while (load_q.size() < n && t < 20) begin
            tick();
            t++;
        end
        chk(name, load_q.size(), n);
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int t = 0;
        while (done_cnt < n && t < budget) begin
            tick();
            t++;
        end
        chk(name, done_cnt, n);
    endtask

    task automatic send_pair(input int a, input int b);
        req0_valid = 1'b1;
        req0_digit = 4'(a);
        req1_valid = 1'b1;
        req1_digit = 4'(b);
        for (int t = 0; t < 10 && (req0_valid || req1_valid); t++) begin
            bit a0, a1;
            #1;
            a0 = req0_valid & req0_ready;
            a1 = req1_valid & req1_ready;
            tick();
            if (a0) req0_valid = 1'b0;
            if (a1) req1_valid = 1'b0;
        end
        chk("pair_both_accepted", {req0_valid, req1_valid}, 0);
        idle_in();
    endtask

    function automatic vec_t mk(input int v0, d0, v1, d1, r0, r1, dp, ld, lg);
        vec_t v;
        v.v0 = v0[0]; v.d0 = d0[3:0]; v.v1 = v1[0]; v.d1 = d1[3:0];
        v.r0 = r0[0]; v.r1 = r1[0]; v.dp = dp[0]; v.ld = ld[0]; v.lg = lg[3:0];
        return v;
    endfunction

    task automatic rand_cycle(input bit active);
        int win, d, nl;
        bit full, exp_drop;
        if (active) begin
            req0_valid = ($urandom_range(0, 2) == 0);
            req1_valid = ($urandom_range(0, 2) == 0);
            req0_digit = 4'($urandom_range(0, 15));
            req1_digit = 4'($urandom_range(0, 15));
            if (coil_run == 0 && $urandom_range(0, 15) == 0) coil_run = int'($urandom_range(1, 12));
        end else begin
            idle_in();
            coil_run = 0;
        end
        coils = (coil_run > 0) ? 4'b0110 : 4'b0000;
        if (coil_run > 0) coil_run--;
        #1;
        full = (mq.size() == DEPTH);
        win = -1;
        if (!full) win = (req0_valid && req1_valid) ? int'(mptr) : req0_valid ? 0 : req1_valid ? 1 : -1;
        chk("rand_ready0", req0_ready, !full && !(req0_valid && req1_valid && win == 1));
        chk("rand_ready1", req1_ready, !full && !(req0_valid && req1_valid && win == 0));
        d = (win == 1) ? int'(req1_digit) : int'(req0_digit);
        nl = load_q.size();
        tick();
        if (cur_pend) begin
            chk("rand_cur_digit", cur_digit, last_ld);
            cur_pend = 1'b0;
        end
        if (load_q.size() > nl) begin
            chk("rand_one_outstanding", outst, 0);
            chk("rand_load_order", load_q[$], mq.size() > 0 ? mq[0] : 99);
            if (mq.size() > 0) void'(mq.pop_front());
            last_ld = load_q[$];
            outst = 1;
        end
        if (done) begin
            chk("rand_done_outstanding", outst, 1);
            outst = 0;
            cur_pend = 1'b1;
        end
        if (win >= 0) begin
            if (d <= 9) mq.push_back(d);
            if (req0_valid && req1_valid) mptr = ~mptr;
        end
        exp_drop = (win >= 0) && (d > 9);
        chk("rand_drop", drop, exp_drop);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        int nl, nd, nr, z, acc_cyc;
        tv[0] = mk(1, 4, 0, 0, 1, 1, 0, 1, 4);
        tv[1] = mk(0, 0, 1, 9, 1, 1, 0, 1, 9);
        tv[2] = mk(0, 0, 1, 12, 1, 1, 1, 0, 0);
        tv[3] = mk(1, 15, 0, 0, 1, 1, 1, 0, 0);
        tv[4] = mk(1, 0, 0, 0, 1, 1, 0, 1, 0);
        tv[5] = mk(1, 2, 1, 6, 1, 0, 0, 1, 2);
        tv[6] = mk(1, 2, 1, 6, 0, 1, 0, 1, 6);
        tv[7] = mk(1, 10, 1, 3, 1, 0, 1, 0, 0);
        tv[8] = mk(1, 7, 1, 8, 0, 1, 0, 1, 8);
        fd = '{1, 2, 3, 5, 7};
        pe = '{2, 6, 6, 2};

        repeat (3) tick();
        chk("reset_drv_en", drv_en, 0);
        chk("reset_ready", {req0_ready, req1_ready}, 0);
        chk("reset_busy", busy, 0);
        chk("reset_drv", {drv_load, drv_digit}, 0);
        chk("reset_status", {cur_digit, drop, done}, 0);
        reset = 1'b0;
        tick();
        chk("run_drv_en", drv_en, 1);
        chk("run_ready", {req0_ready, req1_ready}, 3);

        for (int i = 0; i < 9; i++) begin
            req0_valid = tv[i].v0; req0_digit = tv[i].d0;
            req1_valid = tv[i].v1; req1_digit = tv[i].d1;
            #1;
            chk($sformatf("vec%0d_ready0", i), req0_ready, tv[i].r0);
            chk($sformatf("vec%0d_ready1", i), req1_ready, tv[i].r1);
            nl = load_q.size(); nd = done_cnt; nr = drop_cnt;
            tick();
            idle_in();
            repeat (15) tick();
            chk($sformatf("vec%0d_drops", i), drop_cnt - nr, tv[i].dp);
            chk($sformatf("vec%0d_loads", i), load_q.size() - nl, tv[i].ld);
            chk($sformatf("vec%0d_dones", i), done_cnt - nd, tv[i].ld);
            chk($sformatf("vec%0d_busy", i), busy, 0);
            if (tv[i].ld && load_q.size() > nl) begin
                chk($sformatf("vec%0d_load_digit", i), load_q[$], tv[i].lg);
                chk($sformatf("vec%0d_cur_digit", i), cur_digit, tv[i].lg);
            end
        end

        do_reset(2);
        send_pair(2, 6);
        send_pair(2, 6);
        wait_done(4, 100, "pair_dones");
        for (int i = 0; i < 4; i++) chk($sformatf("pair_order%0d", i), i < load_q.size() ? load_q[i] : 99, pe[i]);

        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1;
            req0_digit = 4'(fd[i]);
            #1;
            chk($sformatf("full_ready_push%0d", i), req0_ready, 1);
            tick();
        end
        idle_in();
        chk("full_ready_at_full", req0_ready, 0);
        begin
            int t = 0;
            while (!req0_ready && t < 40) begin
                tick();
                t++;
            end
        end
        chk("full_ready_returns_on_pop", cyc, load_cyc.size() > 1 ? load_cyc[1] : -1);
        wait_done(5, 120, "full_dones");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("full_order%0d", i), i < load_q.size() ? load_q[i] : 99, fd[i]);
            chk($sformatf("full_nomove_lat%0d", i),
                (i < done_cyc.size() && i < load_cyc.size()) ? done_cyc[i] - load_cyc[i] : -1, NOMOVE_LAT);
        end

        do_reset(2);
        req0_valid = 1'b1;
        req0_digit = 4'd4;
        tick();
        acc_cyc = cyc;
        idle_in();
        wait_load(1, "single_load");
        chk("single_load_latency", load_cyc.size() > 0 ? load_cyc[0] - acc_cyc : -1, 1);
        chk("single_load_digit", load_q.size() > 0 ? load_q[0] : 99, 4);
        coils = 4'b1000;
        repeat (20) tick();
        chk("single_no_early_done", done_cnt, 0);
        chk("single_busy_moving", busy, 1);
        coils = 4'b0000;
        z = cyc;
        wait_done(1, 40, "single_done");
        chk("single_settle_lat", done_cyc.size() > 0 ? done_cyc[0] - z : -1, SETTLE_LAT);
        tick();
        chk("single_cur_digit", cur_digit, 4);
        chk("single_idle", busy, 0);

        do_reset(2);
        req0_valid = 1'b1;
        req0_digit = 4'd3;
        tick();
        idle_in();
        wait_load(1, "glitch_load");
        coils = 4'b0001;
        repeat (6) tick();
        coils = 4'b0000;
        repeat (2) tick();
        coils = 4'b0010;
        repeat (6) tick();
        chk("glitch_no_early_done", done_cnt, 0);
        coils = 4'b0000;
        z = cyc;
        wait_done(1, 40, "glitch_done");
        chk("glitch_settle_lat", done_cyc.size() > 0 ? done_cyc[0] - z : -1, SETTLE_LAT);
        tick();
        chk("glitch_cur_digit", cur_digit, 3);

        do_reset(2);
        req0_valid = 1'b1;
        req0_digit = 4'd5;
        tick();
        idle_in();
        wait_load(1, "rst_first_load");
        coils = 4'b0011;
        req0_valid = 1'b1;
        req0_digit = 4'd6;
        tick();
        req0_digit = 4'd7;
        tick();
        idle_in();
        repeat (3) tick();
        chk("rst_busy_before", busy, 1);
        nl = load_q.size();
        reset = 1'b1;
        tick();
        chk("rst_ctrl_zero", {drv_en, req0_ready, req1_ready, busy, drv_load, done, drop}, 0);
        chk("rst_digits_zero", {drv_digit, cur_digit}, 0);
        reset = 1'b0;
        coils = 4'b0000;
        tick();
        chk("rst_fifo_empty", busy, 0);
        repeat (30) tick();
        chk("rst_no_loads", load_q.size() - nl, 0);
        chk("rst_no_done", done_cnt, 0);

`ifdef STEP_SCHED_ABORT_EN
        do_reset(2);
        req0_valid = 1'b1;
        req0_digit = 4'd5;
        tick();
        idle_in();
        wait_load(1, "abort_first_load");
        coils = 4'b0011;
        req0_valid = 1'b1;
        req0_digit = 4'd6;
        tick();
        req0_digit = 4'd7;
        tick();
        repeat (3) tick();
        nl = load_q.size();
        abort = 1'b1;
        tick();
        chk("abort_drv_en", drv_en, 0);
        chk("abort_ready", {req0_ready, req1_ready}, 0);
        chk("abort_fifo_empty", busy, 0);
        repeat (2) tick();
        chk("abort_drv_en_held", drv_en, 0);
        idle_in();
        abort = 1'b0;
        coils = 4'b0000;
        repeat (30) tick();
        chk("abort_drv_en_back", drv_en, 1);
        chk("abort_no_loads", load_q.size() - nl, 0);
        chk("abort_no_done", done_cnt, 0);
`endif

        do_reset(2);
        mq.delete();
        mptr = 1'b0;
        outst = 0;
        cur_pend = 1'b0;
        coil_run = 0;
        for (int n = 0; n < 400; n++) rand_cycle(1'b1);
        begin
            int t = 0;
            while ((busy || mq.size() > 0 || cur_pend) && t < 600) begin
                rand_cycle(1'b0);
                t++;
            end
        end
        chk("rand_model_drained", mq.size(), 0);
        chk("rand_dut_idle", busy, 0);
        chk("rand_nothing_outstanding", outst, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
